// File: rtl/pc_stack_if.sv
// Fetch-control bus between the core sequencer and the pc_stack stage.
// PC_STACK_ERR_FLAGS_EN adds the sticky stack_ovf / stack_unf status bits.
interface pc_stack_if #(
  parameter int PC_WIDTH = 11
);
  logic                inc_en;
  logic                jump;
  logic                call;
  logic                ret;
  logic                pcl_write;
  logic                skip_req;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] pc_out;
  logic                flush;
  logic                stack_empty;
  logic                stack_full;
`ifdef PC_STACK_ERR_FLAGS_EN
  logic                stack_ovf;
  logic                stack_unf;

  modport master (
    output inc_en, jump, call, ret, pcl_write, skip_req, target,
    input  pc_out, flush, stack_empty, stack_full, stack_ovf, stack_unf
  );
  modport slave (
    input  inc_en, jump, call, ret, pcl_write, skip_req, target,
    output pc_out, flush, stack_empty, stack_full, stack_ovf, stack_unf
  );
`else
  modport master (
    output inc_en, jump, call, ret, pcl_write, skip_req, target,
    input  pc_out, flush, stack_empty, stack_full
  );
  modport slave (
    input  inc_en, jump, call, ret, pcl_write, skip_req, target,
    output pc_out, flush, stack_empty, stack_full
  );
`endif
endinterface

// File: rtl/pc_stack.sv
// Program counter and shift-register return stack; flush squashes the wrong-path fetch.
// Optional macro PC_STACK_ERR_FLAGS_EN enables sticky stack_ovf / stack_unf outputs.
module pc_stack #(
  parameter int                  PC_WIDTH     = 11,
  parameter int                  STACK_DEPTH  = 2,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = {PC_WIDTH{1'b1}}
) (
  input logic       clock,
  input logic       reset,
  pc_stack_if.slave bus
);

  localparam int              CNT_W      = $clog2(STACK_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_INC,
    ACT_SKIP,
    ACT_LOAD,
    ACT_CALL,
    ACT_RET
  } action_e;

  action_e             action;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic                flush_reg, flush_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [PC_WIDTH-1:0] stack_reg  [STACK_DEPTH];
  logic [PC_WIDTH-1:0] stack_next [STACK_DEPTH];
  logic                push, pop, is_empty, is_full;

  assign is_empty = (count_reg == '0);
  assign is_full  = (count_reg == FULL_COUNT);

  // Single priority decode: ret > call > jump > pcl_write > skip_req > inc_en.
  always_comb begin
    action = ACT_HOLD;
    if (bus.ret)                        action = ACT_RET;
    else if (bus.call)                  action = ACT_CALL;
    else if (bus.jump || bus.pcl_write) action = ACT_LOAD;
    else if (bus.skip_req)              action = ACT_SKIP;
    else if (bus.inc_en)                action = ACT_INC;
  end

  always_comb begin
    pc_next    = pc_reg;
    flush_next = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    count_next = count_reg;
    case (action)
      ACT_RET: begin
        pc_next    = stack_reg[0];
        flush_next = 1'b1;
        pop        = 1'b1;
        count_next = is_empty ? count_reg : count_reg - CNT_W'(1);
      end
      ACT_CALL: begin
        pc_next    = bus.target;
        flush_next = 1'b1;
        push       = 1'b1;
        count_next = is_full ? count_reg : count_reg + CNT_W'(1);
      end
      ACT_LOAD: begin
        pc_next    = bus.target;
        flush_next = 1'b1;
      end
      ACT_SKIP: begin
        pc_next    = pc_reg + PC_WIDTH'(1);
        flush_next = 1'b1;
      end
      ACT_INC:  pc_next = pc_reg + PC_WIDTH'(1);
      default:  pc_next = pc_reg;
    endcase
  end

  // Push shifts toward the bottom (oldest falls off); pop shifts up and the bottom entry keeps its value.
  genvar gi;
  generate
    for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
      logic [PC_WIDTH-1:0] shift_down;
      logic [PC_WIDTH-1:0] shift_up;
      if (gi == 0) begin : g_top
        assign shift_down = pc_reg;
      end else begin : g_below
        assign shift_down = stack_reg[gi-1];
      end
      if (gi == STACK_DEPTH - 1) begin : g_bottom
        assign shift_up = stack_reg[gi];
      end else begin : g_above
        assign shift_up = stack_reg[gi+1];
      end
      assign stack_next[gi] = push ? shift_down : (pop ? shift_up : stack_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_reg    <= RESET_VECTOR;
      flush_reg <= 1'b0;
      count_reg <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_reg[i] <= '0;
    end else begin
      pc_reg    <= pc_next;
      flush_reg <= flush_next;
      count_reg <= count_next;
      for (int i = 0; i < STACK_DEPTH; i++) stack_reg[i] <= stack_next[i];
    end
  end

  assign bus.pc_out      = pc_reg;
  assign bus.flush       = flush_reg;
  assign bus.stack_empty = is_empty;
  assign bus.stack_full  = is_full;

`ifdef PC_STACK_ERR_FLAGS_EN
  logic ovf_reg, unf_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      if (push && is_full) ovf_reg <= 1'b1;
      if (pop && is_empty) unf_reg <= 1'b1;
    end
  end

  assign bus.stack_ovf = ovf_reg;
  assign bus.stack_unf = unf_reg;
`endif

endmodule

// File: tb/tb_pc_stack.sv
// Directed-vector bench for pc_stack (PC_WIDTH=11, STACK_DEPTH=2); flag checks follow PC_STACK_ERR_FLAGS_EN.
module tb_pc_stack;

  localparam int PC_WIDTH = 11;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  pc_stack_if #(.PC_WIDTH(PC_WIDTH)) bus ();

  pc_stack #(
    .PC_WIDTH    (PC_WIDTH),
    .STACK_DEPTH (2),
    .RESET_VECTOR(11'h7FF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clear_inputs();
    bus.inc_en    = 1'b0;
    bus.jump      = 1'b0;
    bus.call      = 1'b0;
    bus.ret       = 1'b0;
    bus.pcl_write = 1'b0;
    bus.skip_req  = 1'b0;
    bus.target    = '0;
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
    $display("t=%0t pc=%03h flush=%b empty=%b full=%b", $time, bus.pc_out, bus.flush,
             bus.stack_empty, bus.stack_full);
  endtask

  task automatic goto_pc(input logic [PC_WIDTH-1:0] addr);
    clear_inputs();
    bus.jump   = 1'b1;
    bus.target = addr;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    #12;
    vectors++;
    if (bus.pc_out !== 11'h7FF || bus.flush !== 1'b0 || bus.stack_empty !== 1'b1 || bus.stack_full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: pc=%03h flush=%b empty=%b full=%b, want 7ff 0 1 0",
               bus.pc_out, bus.flush, bus.stack_empty, bus.stack_full);
    end
`ifdef PC_STACK_ERR_FLAGS_EN
    vectors++;
    if (bus.stack_ovf !== 1'b0 || bus.stack_unf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: ovf=%b unf=%b, want 0 0", bus.stack_ovf, bus.stack_unf);
    end
`endif
    reset = 1'b1;
    #1;
  endtask

  task automatic test_inc_wrap();
    logic [PC_WIDTH-1:0] exp_pc [3];
    exp_pc[0] = 11'h000;
    exp_pc[1] = 11'h001;
    exp_pc[2] = 11'h002;
    vectors++;
    if (bus.pc_out !== 11'h7FF) begin
      miscompares++;
      $display("FAIL inc_start: pc=%03h, want 7ff", bus.pc_out);
    end
    bus.inc_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus.pc_out !== exp_pc[i] || bus.flush !== 1'b0 || bus.stack_empty !== 1'b1) begin
        miscompares++;
        $display("FAIL inc_wrap[%0d]: pc=%03h flush=%b empty=%b, want %03h 0 1",
                 i, bus.pc_out, bus.flush, bus.stack_empty, exp_pc[i]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_jump();
    goto_pc(11'h010);
    vectors++;
    if (bus.pc_out !== 11'h010 || bus.flush !== 1'b0) begin
      miscompares++;
      $display("FAIL jump_setup: pc=%03h flush=%b, want 010 0", bus.pc_out, bus.flush);
    end
    bus.jump   = 1'b1;
    bus.inc_en = 1'b1;
    bus.target = 11'h123;
    tick();
    vectors++;
    if (bus.pc_out !== 11'h123 || bus.flush !== 1'b1) begin
      miscompares++;
      $display("FAIL jump_load: pc=%03h flush=%b, want 123 1", bus.pc_out, bus.flush);
    end
    bus.jump = 1'b0;
    tick();
    vectors++;
    if (bus.pc_out !== 11'h124 || bus.flush !== 1'b0) begin
      miscompares++;
      $display("FAIL jump_after: pc=%03h flush=%b, want 124 0", bus.pc_out, bus.flush);
    end
    clear_inputs();
    bus.pcl_write = 1'b1;
    bus.inc_en    = 1'b1;
    bus.target    = 11'h0AB;
    tick();
    vectors++;
    if (bus.pc_out !== 11'h0AB || bus.flush !== 1'b1 || bus.stack_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL pcl_write: pc=%03h flush=%b empty=%b, want 0ab 1 1",
               bus.pc_out, bus.flush, bus.stack_empty);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_call_ret();
    goto_pc(11'h020);
    bus.call   = 1'b1;
    bus.target = 11'h100;
    tick();
    vectors++;
    if (bus.pc_out !== 11'h100 || bus.flush !== 1'b1 || bus.stack_empty !== 1'b0 || bus.stack_full !== 1'b0) begin
      miscompares++;
      $display("FAIL call_load: pc=%03h flush=%b empty=%b full=%b, want 100 1 0 0",
               bus.pc_out, bus.flush, bus.stack_empty, bus.stack_full);
    end
    clear_inputs();
    bus.inc_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    vectors++;
    if (bus.pc_out !== 11'h105 || bus.flush !== 1'b0) begin
      miscompares++;
      $display("FAIL call_body: pc=%03h flush=%b, want 105 0", bus.pc_out, bus.flush);
    end
    clear_inputs();
    bus.ret = 1'b1;
    tick();
    vectors++;
    if (bus.pc_out !== 11'h020 || bus.flush !== 1'b1 || bus.stack_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL ret_pop: pc=%03h flush=%b empty=%b, want 020 1 1",
               bus.pc_out, bus.flush, bus.stack_empty);
    end
    clear_inputs();
    tick();
    vectors++;
    if (bus.pc_out !== 11'h020 || bus.flush !== 1'b0) begin
      miscompares++;
      $display("FAIL ret_hold: pc=%03h flush=%b, want 020 0", bus.pc_out, bus.flush);
    end
  endtask

  task automatic test_nested_overflow();
    logic [PC_WIDTH-1:0] call_tgt [3];
    logic [PC_WIDTH-1:0] ret_exp  [3];
    logic                full_exp [3];
    logic                empty_exp [3];
    call_tgt[0] = 11'h101; call_tgt[1] = 11'h201; call_tgt[2] = 11'h300;
    full_exp[0] = 1'b0;    full_exp[1] = 1'b1;    full_exp[2] = 1'b1;
    ret_exp[0]  = 11'h201; ret_exp[1]  = 11'h101; ret_exp[2]  = 11'h101;
    empty_exp[0] = 1'b0;   empty_exp[1] = 1'b1;   empty_exp[2] = 1'b1;
    goto_pc(11'h001);
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      bus.call   = 1'b1;
      bus.target = call_tgt[i];
      tick();
      vectors++;
      if (bus.pc_out !== call_tgt[i] || bus.flush !== 1'b1 || bus.stack_full !== full_exp[i] || bus.stack_empty !== 1'b0) begin
        miscompares++;
        $display("FAIL nested_call[%0d]: pc=%03h flush=%b full=%b empty=%b, want %03h 1 %b 0",
                 i, bus.pc_out, bus.flush, bus.stack_full, bus.stack_empty, call_tgt[i], full_exp[i]);
      end
    end
`ifdef PC_STACK_ERR_FLAGS_EN
    vectors++;
    if (bus.stack_ovf !== 1'b1 || bus.stack_unf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_flag: ovf=%b unf=%b, want 1 0", bus.stack_ovf, bus.stack_unf);
    end
`endif
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      bus.ret = 1'b1;
      tick();
      vectors++;
      if (bus.pc_out !== ret_exp[i] || bus.flush !== 1'b1 || bus.stack_empty !== empty_exp[i] || bus.stack_full !== 1'b0) begin
        miscompares++;
        $display("FAIL nested_ret[%0d]: pc=%03h flush=%b empty=%b full=%b, want %03h 1 %b 0",
                 i, bus.pc_out, bus.flush, bus.stack_empty, bus.stack_full, ret_exp[i], empty_exp[i]);
      end
`ifdef PC_STACK_ERR_FLAGS_EN
      vectors++;
      if (bus.stack_unf !== (i == 2)) begin
        miscompares++;
        $display("FAIL unf_flag[%0d]: unf=%b, want %b", i, bus.stack_unf, (i == 2));
      end
`endif
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    goto_pc(11'h050);
    bus.skip_req = 1'b1;
    tick();
    vectors++;
    if (bus.pc_out !== 11'h051 || bus.flush !== 1'b1) begin
      miscompares++;
      $display("FAIL skip_no_inc: pc=%03h flush=%b, want 051 1", bus.pc_out, bus.flush);
    end
    bus.jump   = 1'b1;
    bus.target = 11'h300;
    tick();
    vectors++;
    if (bus.pc_out !== 11'h300 || bus.flush !== 1'b1) begin
      miscompares++;
      $display("FAIL jump_over_skip: pc=%03h flush=%b, want 300 1", bus.pc_out, bus.flush);
    end
    // ret must beat a simultaneous call; stack is empty so the bottom-copied 0x101 comes back.
    clear_inputs();
    bus.ret    = 1'b1;
    bus.call   = 1'b1;
    bus.target = 11'h444;
    tick();
    vectors++;
    if (bus.pc_out !== 11'h101 || bus.flush !== 1'b1 || bus.stack_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL ret_over_call: pc=%03h flush=%b empty=%b, want 101 1 1",
               bus.pc_out, bus.flush, bus.stack_empty);
    end
    clear_inputs();
    tick();
    vectors++;
    if (bus.pc_out !== 11'h101 || bus.flush !== 1'b0) begin
      miscompares++;
      $display("FAIL hold: pc=%03h flush=%b, want 101 0", bus.pc_out, bus.flush);
    end
  endtask

  task automatic test_async_reset();
    goto_pc(11'h030);
    bus.call   = 1'b1;
    bus.target = 11'h040;
    tick();
    bus.target = 11'h200;
    vectors++;
    if (bus.pc_out !== 11'h040 || bus.flush !== 1'b1 || bus.stack_empty !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_reset: pc=%03h flush=%b empty=%b, want 040 1 0",
               bus.pc_out, bus.flush, bus.stack_empty);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.pc_out !== 11'h7FF || bus.flush !== 1'b0 || bus.stack_empty !== 1'b1 || bus.stack_full !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: pc=%03h flush=%b empty=%b full=%b, want 7ff 0 1 0",
               bus.pc_out, bus.flush, bus.stack_empty, bus.stack_full);
    end
    tick();
    vectors++;
    if (bus.pc_out !== 11'h7FF || bus.flush !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_held: pc=%03h flush=%b, want 7ff 0", bus.pc_out, bus.flush);
    end
    clear_inputs();
    reset = 1'b1;
    tick();
    vectors++;
    if (bus.pc_out !== 11'h7FF || bus.flush !== 1'b0 || bus.stack_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_hold: pc=%03h flush=%b empty=%b, want 7ff 0 1",
               bus.pc_out, bus.flush, bus.stack_empty);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    clear_inputs();
    test_reset();
    test_inc_wrap();
    test_jump();
    test_call_ret();
    test_nested_overflow();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
